// File: rtl/audio_spi_master.sv
// -----------------------------------------------------------------------------
// audio_spi_master
//
// Byte-oriented SPI master (mode 0, MSB first) fed by a small transmit FIFO.
// Each byte becomes one frame: ss_n low for 17*CLK_DIV clk cycles (one
// CLK_DIV setup period plus eight sck periods), then at least CLK_DIV+1
// cycles of ss_n high before the next frame.
//
// The sck/sdo/ss_n/tx_done outputs are registered from the FSM state.
// This makes them glitch-free, and it places the ss_n fall on the second
// posedge after a byte is accepted into an idle, empty master.
//
// Optional feature macro: SPI_RX_CAPTURE_EN. When defined, sdi is captured
// on every sck rising edge and presented on rx_data/rx_valid at frame end.
// When undefined, rx_data is held at 0x00 and rx_valid is held at 0.
//
// Parameters
//   CLK_DIV    clk cycles per sck half-period (2..255)
//   FIFO_DEPTH transmit FIFO depth (power of two, >= 2)
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   tx_data   in   [7:0] byte to transmit
//   tx_valid  in   tx_data valid
//   tx_ready  out  FIFO not full; accept on tx_valid && tx_ready
//   sck       out  SPI clock, idle low
//   sdo       out  serial data out, MSB first, 0 while ss_n is high
//   ss_n      out  active-low frame select
//   sdi       in   serial data in (capture build only)
//   busy      out  FSM not idle or FIFO non-empty
//   tx_done   out  one-cycle pulse as a frame ends (ss_n rising)
//   rx_data   out  [7:0] last captured byte
//   rx_valid  out  one-cycle pulse with tx_done when rx_data updates
// -----------------------------------------------------------------------------
module audio_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sck,
  output logic       sdo,
  output logic       ss_n,
  input  logic       sdi,
  output logic       busy,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int             PW         = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]    FIFO_FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [7:0]     DIV_LAST   = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;

  logic [7:0]      r_shift;
  logic [7:0]      r_div_cnt;
  logic [3:0]      r_half;        // sck half-period index inside SHIFT: even = high, odd = low

  logic            r_sck;
  logic            r_sdo;
  logic            r_ss_n;
  logic            r_tx_done;

  logic            w_push;
  logic            w_pop;
  logic            w_half_end;
  logic            w_last_half;
  logic            w_frame_active;
  logic            w_gap_first;

  assign w_push         = tx_valid && tx_ready;
  assign w_pop          = (r_state == IDLE) && (r_count != '0);
  assign w_half_end     = (r_div_cnt == DIV_LAST);
  assign w_last_half    = (r_half == 4'd15);
  assign w_frame_active = (r_state == SETUP) || (r_state == SHIFT);
  assign w_gap_first    = (r_state == GAP) && (r_div_cnt == 8'd0);

  assign tx_ready = (r_count != FIFO_FULL);
  assign busy     = (r_state != IDLE) || (r_count != '0);
  assign sck      = r_sck;
  assign sdo      = r_sdo;
  assign ss_n     = r_ss_n;
  assign tx_done  = r_tx_done;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment comes first so that every path assigns
  // w_next_state and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (r_count != '0)              w_next_state = SETUP;
      SETUP:   if (w_half_end)                 w_next_state = SHIFT;
      SHIFT:   if (w_half_end && w_last_half)  w_next_state = GAP;
      GAP:     if (w_half_end)                 w_next_state = IDLE;
      default:                                 w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. An entry is only read after it has
  // been written, because r_count gates the reads. Leaving out the reset lets
  // the array map onto plain RAM/flops without reset logic.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= tx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // State, FIFO pointers, timing counters and shift register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_shift   <= 8'h00;
      r_div_cnt <= 8'd0;
      r_half    <= 4'd0;
    end else begin
      r_state <= w_next_state;

      // The pointers are exactly PW bits wide, so they wrap modulo FIFO_DEPTH.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if ((r_state == IDLE) || w_half_end) r_div_cnt <= 8'd0;
      else                                 r_div_cnt <= r_div_cnt + 1'b1;

      if (r_state != SHIFT)  r_half <= 4'd0;
      else if (w_half_end)   r_half <= r_half + 1'b1;

      if (w_pop) begin
        r_shift <= r_fifo[r_rd_ptr];
      end else if ((r_state == SHIFT) && w_half_end && !r_half[0] && (r_half != 4'd14)) begin
        // Advance at the end of each high half, so sdo moves with the sck
        // fall. The 8th fall is skipped, which holds the LSB on sdo through
        // the final low half.
        r_shift <= {r_shift[6:0], 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered pin outputs (one cycle behind r_state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ss_n    <= 1'b1;
      r_sck     <= 1'b0;
      r_sdo     <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_ss_n    <= !w_frame_active;
      r_sck     <= (r_state == SHIFT) && !r_half[0];
      r_sdo     <= w_frame_active && r_shift[7];
      // The first GAP cycle of r_state is the edge on which ss_n rises.
      r_tx_done <= w_gap_first;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional receive capture
  // ---------------------------------------------------------------------------
`ifdef SPI_RX_CAPTURE_EN
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       w_sck_rise;

  // True on the edge where r_sck goes 0 -> 1, while sdo is still stable.
  assign w_sck_rise = (r_state == SHIFT) && !r_half[0] && !r_sck;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_sck_rise)  r_rx_shift <= {r_rx_shift[6:0], sdi};
      if (w_gap_first) r_rx_data  <= r_rx_shift;
      r_rx_valid <= w_gap_first;
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
`else
  logic w_unused_sdi;

  assign w_unused_sdi = sdi;
  assign rx_data      = 8'h00;
  assign rx_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_audio_spi_master.sv
// -----------------------------------------------------------------------------
// tb_audio_spi_master
//
// Two DUT instances share one clock:
//   dut0: CLK_DIV=4, FIFO_DEPTH=4, sdi looped back from sdo
//   dut1: CLK_DIV=2, FIFO_DEPTH=4, sdi tied low
//
// The stimulus process pushes each tracked byte into a per-DUT expected
// queue when the DUT accepts it. One monitor process per DUT samples on
// the falling clk edge and decodes every frame. On each tx_done it pops
// the expected byte and compares the data and the frame timing.
// -----------------------------------------------------------------------------
module tb_audio_spi_master;

  logic       clk = 1'b0;
  logic [1:0] rst_v = 2'b11;
  logic [7:0] tx_data0 = 8'h00;
  logic [7:0] tx_data1 = 8'h00;
  logic [1:0] tx_valid_v = 2'b00;
  logic [1:0] tx_ready_v;
  logic [1:0] sck_v;
  logic [1:0] sdo_v;
  logic [1:0] ss_n_v;
  logic [1:0] busy_v;
  logic [1:0] tx_done_v;
  logic [1:0] rx_valid_v;
  logic [7:0] rx_data0;
  logic [7:0] rx_data1;
  logic       sdi0;

  int n_cmp = 0;
  int n_bad = 0;
  int idle_err [2] = '{0, 0};

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  always #5 clk = ~clk;

  assign sdi0 = sdo_v[0];

  audio_spi_master #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut0 (
    .clk      (clk),
    .reset    (rst_v[0]),
    .tx_data  (tx_data0),
    .tx_valid (tx_valid_v[0]),
    .tx_ready (tx_ready_v[0]),
    .sck      (sck_v[0]),
    .sdo      (sdo_v[0]),
    .ss_n     (ss_n_v[0]),
    .sdi      (sdi0),
    .busy     (busy_v[0]),
    .tx_done  (tx_done_v[0]),
    .rx_data  (rx_data0),
    .rx_valid (rx_valid_v[0])
  );

  audio_spi_master #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut1 (
    .clk      (clk),
    .reset    (rst_v[1]),
    .tx_data  (tx_data1),
    .tx_valid (tx_valid_v[1]),
    .tx_ready (tx_ready_v[1]),
    .sck      (sck_v[1]),
    .sdo      (sdo_v[1]),
    .ss_n     (ss_n_v[1]),
    .sdi      (1'b0),
    .busy     (busy_v[1]),
    .tx_done  (tx_done_v[1]),
    .rx_data  (rx_data1),
    .rx_valid (rx_valid_v[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  task automatic mon(input int k, input int div);
    logic       p_ss = 1'b1, p_sck = 1'b0, p_sdo = 1'b0, p_done = 1'b0;
    logic       ss, sc, sd, dn, rv;
    logic [7:0] rd;
    logic [7:0] bits = 8'h00;
    logic [7:0] exp_b;
    int         low_len = 0, high_len = 0, run = 0, nbits = 0, sdo_chg = 0, errs = 0, qsz;
    bit         seen = 1'b0;
    string      pfx;
    pfx = $sformatf("dut%0d_", k);
    forever begin
      @(negedge clk);
      ss = ss_n_v[k]; sc = sck_v[k]; sd = sdo_v[k]; dn = tx_done_v[k]; rv = rx_valid_v[k];
      rd = (k == 0) ? rx_data0 : rx_data1;
      if (rst_v[k]) begin
        p_ss = 1'b1; p_sck = 1'b0; p_sdo = 1'b0; p_done = 1'b0;
        seen = 1'b0; low_len = 0; high_len = 0; run = 0; nbits = 0; sdo_chg = 0; errs = 0;
      end else begin
        if (!ss && p_ss) begin
          if (seen) check({pfx, "gap_len_ok"}, int'(high_len >= div + 1), 1);
          low_len = 0; run = 0; nbits = 0; sdo_chg = 0; errs = 0; bits = 8'h00;
        end
        if (!ss) begin
          low_len++;
          if (!p_ss && (sc != p_sck)) begin
            if (run != div) errs++;
            run = 0;
          end
          run++;
          if (!p_ss && sc && !p_sck) begin
            bits = {bits[6:0], sd};
            nbits++;
          end
          if (!p_ss && (sd != p_sdo)) begin
            sdo_chg++;
            if (!(p_sck && !sc)) errs++;
          end
        end else begin
          if (!p_ss) begin
            if (run != div) errs++;
            high_len = 0;
          end
          high_len++;
          if (sd) idle_err[k]++;
        end
        if (dn && p_done) idle_err[k]++;
`ifdef SPI_RX_CAPTURE_EN
        if (rv != dn) idle_err[k]++;
`else
        if (rv || (rd != 8'h00)) idle_err[k]++;
`endif
        if (dn) begin
          qsz = (k == 0) ? exp0.size() : exp1.size();
          check({pfx, "done_expected"}, int'(qsz > 0), 1);
          if (qsz > 0) begin
            if (k == 0) exp_b = exp0.pop_front();
            else        exp_b = exp1.pop_front();
            check({pfx, "done_at_ss_rise"}, int'(ss && !p_ss), 1);
            check({pfx, "ss_low_len"}, low_len, 17 * div);
            check({pfx, "bit_count"}, nbits, 8);
            check({pfx, "data"}, bits, exp_b);
            check({pfx, "protocol_errs"}, errs, 0);
            if (k == 1) check({pfx, "sdo_constant"}, sdo_chg, 0);
`ifdef SPI_RX_CAPTURE_EN
            check({pfx, "rx_valid"}, rv, 1);
            check({pfx, "rx_data"}, rd, (k == 0) ? exp_b : 8'h00);
`else
            check({pfx, "rx_data_zero"}, rd, 0);
            check({pfx, "rx_valid_zero"}, rv, 0);
`endif
          end
          seen = 1'b1;
        end
        p_ss = ss; p_sck = sc; p_sdo = sd; p_done = dn;
      end
    end
  endtask

  initial mon(0, 4);
  initial mon(1, 2);

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push(input int k, input logic [7:0] b, input bit track, output int waited);
    waited = 0;
    @(negedge clk);
    if (k == 0) tx_data0 = b;
    else        tx_data1 = b;
    tx_valid_v[k] = 1'b1;
    while (!tx_ready_v[k] && (waited < 1000)) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready_v[k]) check($sformatf("dut%0d_push_ready", k), tx_ready_v[k], 1);
    @(posedge clk);
    if (track) begin
      if (k == 0) exp0.push_back(b);
      else        exp1.push_back(b);
    end
  endtask

  task automatic valid_off(input int k);
    @(negedge clk);
    tx_valid_v[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_v[k] || !ss_n_v[k]) && (n < 3000));
    check($sformatf("dut%0d_idle_reached", k), busy_v[k], 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int   w;
    int   rises;
    int   guard;
    int   lowc;
    logic psck;

    // Reset state for both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d_rst_ss_n", k),     ss_n_v[k],     1);
      check($sformatf("dut%0d_rst_sck", k),      sck_v[k],      0);
      check($sformatf("dut%0d_rst_sdo", k),      sdo_v[k],      0);
      check($sformatf("dut%0d_rst_tx_done", k),  tx_done_v[k],  0);
      check($sformatf("dut%0d_rst_rx_valid", k), rx_valid_v[k], 0);
      check($sformatf("dut%0d_rst_busy", k),     busy_v[k],     0);
      check($sformatf("dut%0d_rst_tx_ready", k), tx_ready_v[k], 1);
    end
    check("dut0_rst_rx_data", rx_data0, 0);
    check("dut1_rst_rx_data", rx_data1, 0);
    rst_v = 2'b00;
    repeat (3) @(negedge clk);

    // Single byte 0xA5: latency to the ss_n fall, then the frame check in the monitor.
    push(0, 8'hA5, 1, w);
    @(negedge clk);
    tx_valid_v[0] = 1'b0;
    check("lat_ss_n_after_accept", ss_n_v[0], 1);
    @(negedge clk);
    check("lat_ss_n_after_1st_edge", ss_n_v[0], 1);
    @(negedge clk);
    check("lat_ss_n_after_2nd_edge", ss_n_v[0], 0);
    wait_idle(0);

    // Loopback byte 0x3C (rx_data is checked in capture builds).
    push(0, 8'h3C, 1, w);
    valid_off(0);
    wait_idle(0);

    // One byte in flight, then five more pushed back-to-back into the depth-4 FIFO.
    push(0, 8'hC3, 1, w);
    push(0, 8'h11, 1, w);
    push(0, 8'h22, 1, w);
    push(0, 8'h33, 1, w);
    push(0, 8'h44, 1, w);
    @(negedge clk);
    tx_valid_v[0] = 1'b0;
    check("fifo_full_tx_ready", tx_ready_v[0], 0);
    check("fifo_full_busy", busy_v[0], 1);
    push(0, 8'h55, 1, w);
    check("fifth_waited_for_pop", int'(w > 50), 1);
    valid_off(0);
    wait_idle(0);

    // CLK_DIV=2 instance: 0x00 then 0xFF back-to-back.
    push(1, 8'h00, 1, w);
    push(1, 8'hFF, 1, w);
    valid_off(1);
    wait_idle(1);

    // Reset at the 3rd sck rising edge. A second byte stays queued in the FIFO.
    push(0, 8'h96, 0, w);
    push(0, 8'h69, 0, w);
    valid_off(0);
    rises = 0;
    guard = 0;
    psck  = sck_v[0];
    while ((rises < 3) && (guard < 500)) begin
      @(negedge clk);
      guard++;
      if (sck_v[0] && !psck) rises++;
      psck = sck_v[0];
    end
    check("abort_reached_3rd_rise", rises, 3);
    rst_v[0] = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ss_n", ss_n_v[0], 1);
    check("abort_sck", sck_v[0], 0);
    check("abort_sdo", sdo_v[0], 0);
    check("abort_tx_done", tx_done_v[0], 0);
    check("abort_busy", busy_v[0], 0);
    check("abort_tx_ready", tx_ready_v[0], 1);
    @(negedge clk);
    rst_v[0] = 1'b0;
    lowc = 0;
    repeat (150) begin
      @(negedge clk);
      if (!ss_n_v[0] || tx_done_v[0] || busy_v[0]) lowc++;
    end
    check("abort_no_activity", lowc, 0);

    // Normal operation after the abort.
    push(0, 8'h5A, 1, w);
    valid_off(0);
    wait_idle(0);

    repeat (10) @(negedge clk);
    check("dut0_expected_left", exp0.size(), 0);
    check("dut1_expected_left", exp1.size(), 0);
    check("dut0_idle_errors", idle_err[0], 0);
    check("dut1_idle_errors", idle_err[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
